vga_color_arbiter: RTL and testbench
====================================

# vga_color_arbiter

Round-robin arbiter that shares the `vga_gpu` fill-colour input between several requesters (switch debouncer, UART command port, pattern sequencer, etc.). It accepts one colour update at a time over a valid/ready handshake and holds it pending. It commits the update to the GPU colour input only at the next frame boundary, so a frame never changes colour mid-scan. It sits between the requesters and the `color` port of `vga_gpu`, and replaces the direct switch connection in the top level.

## Interface

Parameters:

- `CHANNEL_BITS`, default 4: bits per colour channel.
- `CHANNEL_COUNT`, default 4: channels per colour word. `COLOR_W = CHANNEL_COUNT*CHANNEL_BITS`.
- `NUM_REQ`, default 4: number of requesters, ≥ 2.
- `ID_BITS`, default 2: width of the requester index, equal to ceil(log2(NUM_REQ)).
- `RESET_COLOR`, default 0: value of `color` after reset (`COLOR_W` bits).

Ports:

- `clk`  in  1  pixel clock; the single clock domain.
- `aresetn`  in  1  reset; synchronous, active-low.
- `req_valid`  in  NUM_REQ  bit i: requester i offers a colour.
- `req_color`  in  NUM_REQ*COLOR_W  slice [i*COLOR_W +: COLOR_W] holds requester i's colour.
- `req_ready`  out  NUM_REQ  one-hot or zero; bit i: requester i's offer is taken this cycle.
- `frame_start`  in  1  single-cycle pulse from the timing generator on the first cycle of vertical blanking.
- `color`  out  COLOR_W  registered colour driven into `vga_gpu` `color`.
- `pending`  out  1  registered; high while a colour is latched and waiting for commit.
- `grant_id`  out  ID_BITS  registered; index of the requester that owns the pending or most recent committed colour.

## Operation

- **States:** IDLE and HOLD. The state register is encoded as `pending`: IDLE = 0, HOLD = 1.
- **Round-robin pointer:** `ptr` is `ID_BITS` wide and resets to 0.
- **Arbitration in IDLE:**
  - The winner is the first i with `req_valid[i]=1`, scanning i = ptr, ptr+1, …, ptr+NUM_REQ-1, taken modulo NUM_REQ.
  - `req_ready` is combinational: the one-hot of the winner. It is all-zero if no valid is set.
- **Accept:** an accept occurs when `req_valid[i] & req_ready[i]`. On the next edge:
  - `pend_color <= req_color[i]`
  - `grant_id <= i`
  - `ptr <= (i+1) mod NUM_REQ`
  - state moves to HOLD.
- **HOLD:**
  - `req_ready` is all-zero, and requesters keep their valid/colour stable.
  - `frame_start=1` commits: `color <= pend_color`, and state returns to IDLE.
  - `grant_id` keeps its value through the commit.
- **`frame_start` in IDLE:** no effect; `color` is unchanged.
- **Accept and `frame_start` in the same IDLE cycle:** the accept wins and the state moves to HOLD. The commit waits for the next `frame_start`; it never occurs in the same frame.
- **Reset:**
  - While `aresetn=0` at an edge: `color=RESET_COLOR`, `pending=0`, `grant_id=0`, `ptr=0`, `pend_color=0`.
  - `req_ready` is forced to 0 whenever `aresetn=0`.
  - Reset during HOLD discards the pending colour; no commit occurs.
- **Dropped requests:** a requester that drops `req_valid` before being granted loses nothing, and no state changes.
- **Arithmetic:** pointer increment and scan index wrap modulo NUM_REQ. When NUM_REQ is not a power of two, the value NUM_REQ-1 wraps to 0, never to an unused code.

## Timing

- **Accept latency:** accept at edge N gives `pending=1` and an updated `grant_id` after N. From N+1, `req_ready` is 0.
- **Commit latency:** `frame_start` sampled at edge M in HOLD gives an updated `color` and `pending=0` after M. `req_ready` can assert from cycle M+1.
- **Throughput:** at most one colour change per frame.
- **Worst-case wait:** a requester holding `req_valid` high waits at most NUM_REQ-1 other grants, i.e. ≤ NUM_REQ-1 frames.
- **Registered outputs:** `color`, `pending` and `grant_id` are registered.
- **Combinational output:** `req_ready` is combinational from `req_valid`, `ptr` and state only. It has no dependency on `req_color`.

## Test plan

- **Reset:** assert `aresetn=0` for 3 cycles with all `req_valid=1`. Required: `color=RESET_COLOR`, `pending=0`, `grant_id=0`, `req_ready=0` throughout; after release, `req_ready=4'b0001` in the first cycle.
- **Single request:** requester 2 offers 16'hF00F; no other valid. Required: `req_ready=4'b0100`, then `pending=1`, `grant_id=2`. `color` stays unchanged until `frame_start`, then equals 16'hF00F one cycle later with `pending=0`.
- **Fairness:** all four requesters hold valid with distinct colours; pulse `frame_start` every 100 cycles. Required: grant order 0,1,2,3,0. Each committed colour matches its requester's colour.
- **Idle frame:** pulse `frame_start` with no pending request. Required: `color` unchanged, `pending=0`.
- **Same-cycle collision:** requester 1 is valid in the same IDLE cycle as `frame_start`. Required: accept, then `pending=1`, and `color` is unchanged until the following `frame_start` pulse.
- **Reset in HOLD:** reach HOLD with 16'h0FF0 pending, assert reset for 1 cycle, then pulse `frame_start`. Required: `color=RESET_COLOR`, `pending=0`; 16'h0FF0 is never driven.

Source files
------------

// File: rtl/vga_color_arbiter.sv
// Round-robin arbiter feeding the vga_gpu fill colour; one update is accepted per
// valid/ready handshake and only committed to `color` on the next frame_start pulse.
module vga_color_arbiter #(
  parameter int CHANNEL_BITS  = 4,
  parameter int CHANNEL_COUNT = 4,
  parameter int NUM_REQ       = 4,
  parameter int ID_BITS       = 2,
  parameter logic [CHANNEL_COUNT*CHANNEL_BITS-1:0] RESET_COLOR = '0
) (
  input  logic                                    clk,
  input  logic                                    aresetn,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ*CHANNEL_COUNT*CHANNEL_BITS-1:0] req_color,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic                                    frame_start,
  output logic [CHANNEL_COUNT*CHANNEL_BITS-1:0]   color,
  output logic                                    pending,
  output logic [ID_BITS-1:0]                      grant_id
);

  localparam int COLOR_W = CHANNEL_COUNT * CHANNEL_BITS;

  logic [ID_BITS-1:0] ptr;
  logic [ID_BITS-1:0] ptr_nxt;
  logic [COLOR_W-1:0] pend_color;
  logic               next_pending;

  logic               found;
  logic [ID_BITS-1:0] win;
  logic [ID_BITS-1:0] idx;
  logic               accept;

  // Scan from ptr upward; the modulo keeps the index inside 0..NUM_REQ-1
  // even when NUM_REQ is not a power of two.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_BITS'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign accept  = aresetn && !pending && found;
  assign ptr_nxt = (win == ID_BITS'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  // State register: pending encodes IDLE (0) / HOLD (1).
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      pending <= 1'b0;
    end else begin
      pending <= next_pending;
    end
  end

  // Next-state logic: an accept in IDLE takes priority over a coincident frame_start,
  // so a freshly latched colour always waits for the following frame.
  always_comb begin
    next_pending = pending;
    if (!pending) begin
      if (accept) begin
        next_pending = 1'b1;
      end
    end else if (frame_start) begin
      next_pending = 1'b0;
    end
  end

  // Output logic: ready depends only on valid, ptr and state.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready = NUM_REQ'(1) << win;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      pend_color <= '0;
      grant_id   <= '0;
      ptr        <= '0;
    end else if (accept) begin
      pend_color <= req_color[win*COLOR_W +: COLOR_W];
      grant_id   <= win;
      ptr        <= ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      color <= RESET_COLOR;
    end else if (pending && frame_start) begin
      color <= pend_color;
    end
  end

endmodule

// File: tb/tb_vga_color_arbiter.sv
// Directed bench for vga_color_arbiter: a table of per-cycle vectors plus
// hand-written fairness and reset-in-HOLD sequences.
module tb_vga_color_arbiter;

  localparam logic [15:0] RST_COL = 16'hABCD;

  logic        clk;
  logic        aresetn;
  logic [3:0]  req_valid;
  logic [63:0] req_color;
  logic [3:0]  req_ready;
  logic        frame_start;
  logic [15:0] color;
  logic        pending;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  vga_color_arbiter #(
    .CHANNEL_BITS (4),
    .CHANNEL_COUNT(4),
    .NUM_REQ      (4),
    .ID_BITS      (2),
    .RESET_COLOR  (RST_COL)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .req_valid  (req_valid),
    .req_color  (req_color),
    .req_ready  (req_ready),
    .frame_start(frame_start),
    .color      (color),
    .pending    (pending),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic        fs;
    logic [3:0]  ready;
    logic        pend;
    logic [1:0]  gid;
    logic [15:0] col;
  } vec_t;

  vec_t tbl [20];
  logic [15:0] cols [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cols[0] = 16'h1111;
    cols[1] = 16'h2222;
    cols[2] = 16'hF00F;
    cols[3] = 16'h3333;

    // Registered outputs in each row are the values left by the previous edge.
    //              rst  valid    fs  ready    pend  gid   color
    tbl[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, RST_COL};
    tbl[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, RST_COL};
    tbl[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, RST_COL};
    tbl[3]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0, RST_COL};
    tbl[4]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, RST_COL};
    tbl[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, RST_COL};
    tbl[6]  = '{1'b1, 4'b1111, 1'b0, 4'b0010, 1'b0, 2'd0, 16'h1111};
    tbl[7]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 16'h1111};
    tbl[8]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 16'h2222};
    tbl[9]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, 2'd1, 16'h2222};
    tbl[10] = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h2222};
    tbl[11] = '{1'b1, 4'b0100, 1'b1, 4'b0000, 1'b1, 2'd2, 16'h2222};
    tbl[12] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 16'hF00F};
    tbl[13] = '{1'b1, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd2, 16'hF00F};
    tbl[14] = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, 16'hF00F};
    tbl[15] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 16'hF00F};
    tbl[16] = '{1'b1, 4'b1001, 1'b0, 4'b1000, 1'b0, 2'd1, 16'h2222};
    tbl[17] = '{1'b1, 4'b1001, 1'b1, 4'b0000, 1'b1, 2'd3, 16'h2222};
    tbl[18] = '{1'b1, 4'b1001, 1'b0, 4'b0001, 1'b0, 2'd3, 16'h3333};
    tbl[19] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h3333};

    req_color   = {cols[3], cols[2], cols[1], cols[0]};
    aresetn     = 1'b0;
    req_valid   = 4'b1111;
    frame_start = 1'b0;
    step();

    for (int i = 0; i < 20; i++) begin
      aresetn     = tbl[i].rst_n;
      req_valid   = tbl[i].valid;
      frame_start = tbl[i].fs;
      #1;
      chk($sformatf("vec%0d.req_ready", i), 32'(req_ready), 32'(tbl[i].ready));
      chk($sformatf("vec%0d.pending", i),   32'(pending),   32'(tbl[i].pend));
      chk($sformatf("vec%0d.grant_id", i),  32'(grant_id),  32'(tbl[i].gid));
      chk($sformatf("vec%0d.color", i),     32'(color),     32'(tbl[i].col));
      step();
    end

    // Fairness: all requesters valid, frame_start every 100 cycles.
    frame_start = 1'b0;
    req_valid   = 4'b1111;
    aresetn     = 1'b0;
    step();
    aresetn = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int c = 0; c < 99; c++) step();
      chk($sformatf("fair%0d.pending", f),  32'(pending),  32'd1);
      chk($sformatf("fair%0d.grant_id", f), 32'(grant_id), 32'(f % 4));
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk($sformatf("fair%0d.color", f),    32'(color),    32'(cols[f % 4]));
      chk($sformatf("fair%0d.commit_pending", f), 32'(pending), 32'd0);
    end

    // Reset while HOLD: the pending 0FF0 must never reach color.
    req_valid = 4'b0000;
    step();
    req_color[31:16] = 16'h0FF0;
    req_valid = 4'b0010;
    #1;
    chk("hold.req_ready", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b0000;
    chk("hold.pending",  32'(pending),  32'd1);
    chk("hold.grant_id", 32'(grant_id), 32'd1);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    chk("hold_rst.color",   32'(color),   32'(RST_COL));
    chk("hold_rst.pending", 32'(pending), 32'd0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("hold_fs.color",   32'(color),   32'(RST_COL));
    chk("hold_fs.pending", 32'(pending), 32'd0);
    step();
    chk("hold_after.color", 32'(color), 32'(RST_COL));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
